seg7_scan_n: RTL and testbench

SEG7_SCAN_N -- requirements
Module: seg7_scan_n

---
 rtl/seg7_scan_n.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_n.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_n.sv
`default_nettype none
// ============================================================================
// seg7_scan_n : multiplexed N-digit 7-segment scanner, hex/raw modes,
//               frame-synchronous double-buffered load, blanking and blink
// Revision    : 1.0
// ============================================================================
module seg7_scan_n #(
    parameter int N_DIGITS = 8,
    parameter int DIV_W    = 15,
    parameter int BLINK_W  = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic                  i_mode,
    input  logic [4*N_DIGITS-1:0] i_data,
    input  logic [8*N_DIGITS-1:0] i_raw,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blink,
    input  logic                  i_lzs,
    output logic [7:0]            o_seg,
    output logic [N_DIGITS-1:0]   o_sel,
    output logic                  o_frame,
    output logic                  o_pend
);

    localparam int            AW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_DIGITS - 1);

    typedef struct packed {
        logic                  mode;
        logic [4*N_DIGITS-1:0] data;
        logic [8*N_DIGITS-1:0] raw;
        logic [N_DIGITS-1:0]   dp;
        logic [N_DIGITS-1:0]   blink;
        logic                  lzs;
    } cfg_t;

    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [BLINK_W-1:0]  fcnt_q, fcnt_d;
    logic                frame_q, frame_d;
    logic                pend_q, pend_d;
    cfg_t                pnd_q, pnd_d;
    cfg_t                act_q, act_d;
    logic [7:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;

    logic       tick;
    logic       boundary;
    logic [3:0] cur_nib;
    logic [7:0] cur_raw;
    logic       cur_dp;
    logic       cur_blink;
    logic       cur_lz;
    logic       tail_zero;

    // Lower seven bits of the active-low hex glyph; bit 7 carries the dp.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick     = &cnt_q;
        boundary = tick && (addr_q == LAST_ADDR);
        cnt_d    = cnt_q + 1'b1;
        addr_d   = addr_q;
        if (boundary)
            addr_d = '0;
        else if (tick)
            addr_d = addr_q + 1'b1;
        fcnt_d  = boundary ? fcnt_q + 1'b1 : fcnt_q;
        frame_d = boundary;

        // Commit uses the old pending copy, so a load on the boundary
        // cycle is simply queued for the following frame.
        act_d  = act_q;
        pnd_d  = pnd_q;
        pend_d = pend_q;
        if (boundary && pend_q) begin
            act_d  = pnd_q;
            pend_d = 1'b0;
        end
        if (load) begin
            pnd_d  = {i_mode, i_data, i_raw, i_dp, i_blink, i_lzs};
            pend_d = 1'b1;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_raw   = '1;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        tail_zero = 1'b1;
        sel_d     = '1;
        // Walk from the most significant digit so tail_zero covers k..N-1.
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            tail_zero = tail_zero && (act_q.data[4*k +: 4] == 4'h0) && !act_q.dp[k];
            if (addr_q == AW'(k)) begin
                cur_nib   = act_q.data[4*k +: 4];
                cur_raw   = act_q.raw[8*k +: 8];
                cur_dp    = act_q.dp[k];
                cur_blink = act_q.blink[k];
                cur_lz    = tail_zero && (k != 0);
                sel_d[k]  = 1'b0;
            end
        end

        seg_d = {~cur_dp, hex7(cur_nib)};
        if (act_q.mode)
            seg_d = cur_raw;
        else if (act_q.lzs && cur_lz)
            seg_d = 8'hFF;
        if (cur_blink && fcnt_q[BLINK_W-1])
            seg_d = 8'hFF;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            fcnt_q  <= '0;
            frame_q <= 1'b0;
            pend_q  <= 1'b0;
            pnd_q   <= '0;
            act_q   <= '0;
            seg_q   <= 8'hFF;
            sel_q   <= '1;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            fcnt_q  <= fcnt_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            pnd_q   <= pnd_d;
            act_q   <= act_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_sel   = sel_q;
    assign o_frame = frame_q;
    assign o_pend  = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_n.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_n : frame-level scoreboard bench for seg7_scan_n (4 digits)
// Revision       : 1.0
// ============================================================================
module tb_seg7_scan_n;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        load = 1'b0;
    logic        i_mode = 1'b0;
    logic [15:0] i_data = '0;
    logic [31:0] i_raw = '0;
    logic [3:0]  i_dp = '0;
    logic [3:0]  i_blink = '0;
    logic        i_lzs = 1'b0;
    logic [7:0]  o_seg;
    logic [3:0]  o_sel;
    logic        o_frame;
    logic        o_pend;

    seg7_scan_n #(.N_DIGITS(4), .DIV_W(2), .BLINK_W(2)) dut (
        .clk(clk), .rstn(rstn), .load(load), .i_mode(i_mode),
        .i_data(i_data), .i_raw(i_raw), .i_dp(i_dp), .i_blink(i_blink),
        .i_lzs(i_lzs), .o_seg(o_seg), .o_sel(o_sel), .o_frame(o_frame),
        .o_pend(o_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [31:0] raw;
        logic [3:0]  dp;
        logic [3:0]  blink;
        logic        lzs;
        logic [31:0] expv;   // unblinked display, {d3,d2,d1,d0}
    } sc_t;

    sc_t         tbl[10];
    logic [31:0] exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          base = 0;
    int          act = 0;
    int          pend = 0;
    bit          pend_v = 1'b0;
    bit          bnd_done = 1'b0;

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic init_tbl();
        tbl[0] = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 4'h0, 1'b0, 32'hC0C0C0C0};
        tbl[1] = '{1'b0, 16'h12AF, 32'h00000000, 4'h2, 4'h0, 1'b0, 32'hF9A4088E};
        tbl[2] = '{1'b0, 16'h0005, 32'h00000000, 4'h0, 4'h0, 1'b1, 32'hFFFFFF92};
        tbl[3] = '{1'b0, 16'h0005, 32'h00000000, 4'h4, 4'h0, 1'b1, 32'hFF40C092};
        tbl[4] = '{1'b1, 16'hFFFF, 32'h00FF7F3C, 4'hF, 4'h1, 1'b1, 32'h00FF7F3C};
        tbl[5] = '{1'b0, 16'h3456, 32'h00000000, 4'h0, 4'h0, 1'b0, 32'hB0999282};
        tbl[6] = '{1'b0, 16'h00C0, 32'h00000000, 4'h0, 4'h0, 1'b1, 32'hFFFFC6C0};
        tbl[7] = '{1'b0, 16'h789B, 32'h00000000, 4'h8, 4'hA, 1'b0, 32'h78809083};
        tbl[8] = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 4'h0, 1'b1, 32'hFFFFFFC0};
        tbl[9] = '{1'b0, 16'hE0D0, 32'h00000000, 4'h0, 4'h0, 1'b0, 32'h86C0A1C0};
    endtask

    // Frame f is blinked while the frame counter (f mod 4) has its MSB set.
    function automatic logic [31:0] disp(input int sc, input int f);
        logic [31:0] v;
        v = tbl[sc].expv;
        if ((f % 4) >= 2)
            for (int k = 0; k < 4; k++)
                if (tbl[sc].blink[k]) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic wait_neg(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_seg"},   o_seg,   32'hFF);
        check({tag, "_sel"},   o_sel,   32'hF);
        check({tag, "_frame"}, o_frame, 32'h0);
        check({tag, "_pend"},  o_pend,  32'h0);
    endtask

    task automatic frame_begin();
        base = cyc;
        check("o_pend_frame", o_pend, 32'(pend_v));
        exp_q.push_back(disp(act, base / 16));
    endtask

    task automatic load_at(input int off, input int sc);
        wait_neg(base + off - 1);
        i_mode  = tbl[sc].mode;
        i_data  = tbl[sc].data;
        i_raw   = tbl[sc].raw;
        i_dp    = tbl[sc].dp;
        i_blink = tbl[sc].blink;
        i_lzs   = tbl[sc].lzs;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (off == 16) begin
            if (pend_v) act = pend;
            pend     = sc;
            pend_v   = 1'b1;
            bnd_done = 1'b1;
        end else begin
            pend   = sc;
            pend_v = 1'b1;
            check("o_pend_set", o_pend, 32'h1);
        end
    endtask

    task automatic frame_end();
        wait_neg(base + 16);
        if (!bnd_done && pend_v) begin
            act    = pend;
            pend_v = 1'b0;
        end
        bnd_done = 1'b0;
    endtask

    initial begin : monitor
        logic [31:0] cur;
        logic [3:0]  sel_exp;
        int c, d, p;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && cyc >= 1) begin
                c = cyc;
                d = ((c - 1) / 4) % 4;
                p = (c - 1) % 4;
                if (p == 1 && d == 0) begin
                    check("sb_avail", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                end
                if (p == 1) begin
                    sel_exp    = '1;
                    sel_exp[d] = 1'b0;
                    check("o_sel", o_sel, sel_exp);
                end
                if (p == 1 || p == 3)
                    check($sformatf("o_seg_d%0d", d), o_seg, cur[8*d +: 8]);
                if (p == 0 || p == 3)
                    check("o_frame", o_frame, 32'(c % 16 == 0));
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin : driver
        init_tbl();
        #2 rstn = 1'b0;
        #1 reset_checks("rst0");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        frame_begin(); frame_end();                                   // f0
        frame_begin(); frame_end();                                   // f1
        frame_begin(); load_at(5, 1); frame_end();                    // f2
        frame_begin(); load_at(7, 2); frame_end();                    // f3
        frame_begin(); load_at(3, 3); frame_end();                    // f4
        frame_begin(); load_at(9, 8); frame_end();                    // f5
        frame_begin(); load_at(2, 4); frame_end();                    // f6
        repeat (4) begin frame_begin(); frame_end(); end              // f7-f10
        frame_begin(); load_at(4, 7); frame_end();                    // f11
        repeat (3) begin frame_begin(); frame_end(); end              // f12-f14
        frame_begin(); load_at(3, 9); load_at(10, 5); frame_end();    // f15
        frame_begin(); load_at(6, 2); load_at(16, 6); frame_end();    // f16
        frame_begin(); frame_end();                                   // f17
        frame_begin(); frame_end();                                   // f18
        frame_begin(); load_at(5, 3);                                 // f19
        wait_neg(base + 8);
        #2 rstn = 1'b0;
        #1 reset_checks("rst1");
        exp_q.delete();
        act      = 0;
        pend_v   = 1'b0;
        bnd_done = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) begin frame_begin(); frame_end(); end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
